// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_unit_pkg
// Brief    : Shared opcode, reset-vector and state encoding for the fetch unit
// Revision : 1.0
// ============================================================================
package fetch_unit_pkg;

    localparam logic [7:0]  c_NOP          = 8'hEA;
    localparam logic [15:0] c_RESET_VECTOR = 16'hFFFC;

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Byte-wide synchronous FIFO with clear and occupancy count
// Revision : 1.0
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_2,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [7:0]       head,
    output logic [CNT_W-1:0] count
);
    localparam int c_PTR_W = $clog2(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_2 or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_2) begin
        if (push && !clear) r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Boots from the reset vector, then prefetches bytes into a queue
// Revision : 1.0
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [15:0] RESET_VECTOR = c_RESET_VECTOR
) (
    input  logic        clk_2,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  instruction,
    output logic        instr_valid,
    input  logic        consume,
    input  logic        branch_load,
    input  logic [15:0] branch_target,
    output logic        flush,
    output logic [15:0] fetch_pc
);
    localparam int                 c_CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    fetch_state_e       r_state, w_state_next;
    logic [7:0]         r_vec_lo, w_vec_lo_next;
    logic [15:0]        r_fetch_addr, w_fetch_addr_next;
    logic [15:0]        r_fetch_pc, w_fetch_pc_next;
    logic               r_mem_req, w_mem_req_next;
    logic [15:0]        r_mem_addr, w_mem_addr_next;
    logic               r_discard, w_discard_next;
    logic               r_flush, w_flush_next;
    logic               w_ack, w_push, w_pop, w_clear, w_hold, w_issue;
    logic [7:0]         w_head;
    logic [c_CNT_W-1:0] w_count, w_count_next;

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (c_CNT_W)
    ) u_queue (
        .clk_2     (clk_2),
        .rst       (rst),
        .push      (w_push),
        .push_data (mem_rdata),
        .pop       (w_pop),
        .clear     (w_clear),
        .head      (w_head),
        .count     (w_count)
    );

    always_ff @(posedge clk_2 or negedge rst) begin
        if (!rst) begin
            r_state      <= VEC_LO;
            r_vec_lo     <= '0;
            r_fetch_addr <= '0;
            r_fetch_pc   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= RESET_VECTOR;
            r_discard    <= 1'b0;
            r_flush      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_vec_lo     <= w_vec_lo_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_fetch_pc   <= w_fetch_pc_next;
            r_mem_req    <= w_mem_req_next;
            r_mem_addr   <= w_mem_addr_next;
            r_discard    <= w_discard_next;
            r_flush      <= w_flush_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_vec_lo_next     = r_vec_lo;
        w_fetch_addr_next = r_fetch_addr;
        w_fetch_pc_next   = r_fetch_pc;
        w_discard_next    = r_discard;
        w_flush_next      = 1'b0;
        w_push            = 1'b0;
        w_pop             = 1'b0;
        w_clear           = 1'b0;
        w_ack             = r_mem_req & mem_ack;

        case (r_state)
            VEC_LO: begin
                if (w_ack) begin
                    w_vec_lo_next = mem_rdata;
                    w_state_next  = VEC_HI;
                end
            end
            VEC_HI: begin
                if (w_ack) begin
                    w_fetch_addr_next = {mem_rdata, r_vec_lo};
                    w_fetch_pc_next   = {mem_rdata, r_vec_lo};
                    w_state_next      = RUN;
                end
            end
            RUN: begin
                // A redirect overrides any same-cycle push or pop; a request
                // still in flight is left to finish and its byte dropped.
                if (branch_load) begin
                    w_clear           = 1'b1;
                    w_fetch_addr_next = branch_target;
                    w_fetch_pc_next   = branch_target;
                    w_flush_next      = 1'b1;
                    w_discard_next    = r_mem_req & ~mem_ack;
                end else begin
                    if (w_ack) begin
                        if (r_discard) begin
                            w_discard_next = 1'b0;
                        end else begin
                            w_push            = 1'b1;
                            w_fetch_addr_next = r_fetch_addr + 16'd1;
                        end
                    end
                    if (consume && instr_valid) begin
                        w_pop           = 1'b1;
                        w_fetch_pc_next = r_fetch_pc + 16'd1;
                    end
                end
            end
            default: w_state_next = VEC_LO;
        endcase

        w_count_next = w_clear ? '0
                     : w_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

        // Requests are registered so that the bus sees a new address the
        // cycle after the decision, and an unanswered one is held unchanged.
        w_hold          = r_mem_req & ~mem_ack;
        w_issue         = ~w_hold & ((w_state_next != RUN) || (w_count_next < c_DEPTH_CNT));
        w_mem_req_next  = w_hold | w_issue;
        w_mem_addr_next = r_mem_addr;
        if (w_issue) begin
            case (w_state_next)
                VEC_LO:  w_mem_addr_next = RESET_VECTOR;
                VEC_HI:  w_mem_addr_next = RESET_VECTOR + 16'd1;
                default: w_mem_addr_next = w_fetch_addr_next;
            endcase
        end
    end

    assign instr_valid = (w_count != '0);
    assign instruction = instr_valid ? w_head : c_NOP;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign flush       = r_flush;
    assign fetch_pc    = r_fetch_pc;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue depth in bytes (power of two, 2..16).
REQ-002 SHALL have parameter RESET_VECTOR, default 16'hFFFC, address of the reset vector low byte.
REQ-003 SHALL have port clk_2  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port mem_req  output  1  memory read request.
REQ-006 SHALL have port mem_addr  output  16  read address, valid while mem_req=1.
REQ-007 SHALL have port mem_ack  input  1  read completes this cycle; mem_rdata valid.
REQ-008 SHALL have port mem_rdata  input  8  read data.
REQ-009 SHALL have port instruction  output  8  head byte of queue, to decoder.
REQ-010 SHALL have port instr_valid  output  1  queue non-empty.
REQ-011 SHALL have port consume  input  1  decoder pops head byte.
REQ-012 SHALL have port branch_load  input  1  redirect fetch to branch_target.
REQ-013 SHALL have port branch_target  input  16  redirect address.
REQ-014 SHALL have port flush  output  1  one-cycle pulse to decoder after redirect.
REQ-015 SHALL have port fetch_pc  output  16  address of head byte.

Function
REQ-016 SHALL implement states VEC_LO, VEC_HI, RUN; leaves reset in VEC_LO.
REQ-017 VEC_LO: mem_req=1, mem_addr=RESET_VECTOR; on mem_ack store low byte, go VEC_HI.
REQ-018 VEC_HI: mem_req=1, mem_addr=RESET_VECTOR+1; on mem_ack set fetch address and fetch_pc to {mem_rdata, low}, go RUN.
REQ-019 Bus: at most one outstanding request; mem_req and mem_addr held stable until mem_ack; mem_req may reassert the cycle after mem_ack.
REQ-020 RUN: request issued only when occupancy + outstanding < DEPTH; on mem_ack byte pushed, fetch address += 1, wrapping 16'hFFFF -> 16'h0000.
REQ-021 Pushed byte visible on instruction/instr_valid the cycle after mem_ack (1-cycle latency, ack to valid).
REQ-022 consume with instr_valid=1 pops head, fetch_pc += 1 (wraps); consume with instr_valid=0 ignored, no state change.
REQ-023 Simultaneous push and pop SHALL keep occupancy constant, preserving byte order.
REQ-024 instruction SHALL read 8'hEA (NOP) when instr_valid=0.
REQ-025 branch_load in RUN: queue emptied, fetch address and fetch_pc = branch_target, flush=1 next cycle only.
REQ-026 branch_load with request outstanding: mem_req/mem_addr stay held until mem_ack; that returned byte discarded; next request uses branch_target.
REQ-027 branch_load in same cycle as mem_ack or consume: redirect wins; byte discarded, pop ignored.
REQ-028 branch_load in VEC_LO/VEC_HI SHALL be ignored.

Reset
REQ-029 rst=0 SHALL immediately force: state VEC_LO, queue empty, instr_valid=0, instruction=8'hEA, mem_req=0, mem_addr=RESET_VECTOR, flush=0, fetch_pc=16'h0000, outstanding/discard flags cleared.
REQ-030 Reset mid-transaction SHALL abandon the request; first post-reset request is to RESET_VECTOR the cycle after rst rises.

Structure
REQ-031 Shared package SHALL hold NOP opcode 8'hEA, default reset vector 16'hFFFC, and state encoding.
REQ-032 Queue SHALL be sub-module fetch_queue (synchronous FIFO, push/pop/clear, count).

Verification
REQ-033 Reset boot: vector bytes 34@FFFC, 12@FFFD, zero-wait ack -> requests FFFC, FFFD, then 1234; fetch_pc=1234.
REQ-034 Fill: consume=0, DEPTH=4 -> exactly 4 requests 1234..1237, mem_req stays 0, instr_valid=1, instruction = byte@1234.
REQ-035 Wrap: vector FFFE, bytes A9,05,EA -> fetch_pc FFFE, FFFF, 0000 after successive pops; third request addr 0000.
REQ-036 Redirect with outstanding request (ack delayed 3 cycles), branch_target=2000 -> held request completes, byte dropped, flush pulses once, next request 2000, instr_valid=0 until 2000 data returns.
REQ-037 Simultaneous branch_load, mem_ack, consume -> queue empty, fetch_pc=branch_target, no byte delivered.
REQ-038 rst=0 while mem_req=1 awaiting ack -> outputs at reset values immediately; after release, request to FFFC.
